ifu_prefetch: RTL and testbench



---
 rtl/ifu_prefetch_pkg.sv | 18 +
 rtl/ifu_prefetch_fifo.sv | 77 +++++++
 rtl/ifu_prefetch.sv | 172 +++++++++++++++++
 tb/tb_ifu_prefetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and the fetch-buffer entry type used by the instruction-fetch unit.
package ysyx_23060124_pkg;

  localparam logic [31:0] RESET_PC       = 32'h3000_0000;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;

  // Entry pc field is fixed at 32 bits; the fetch unit's ADDR_W must not exceed it.
  localparam int IFU_PC_W = 32;

  typedef struct packed {
    logic [IFU_PC_W-1:0] pc;
    logic [31:0]         ins;
    logic                err;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous prefetch buffer; flush beats push and pop in the same cycle.
module ifu_fifo
  import ysyx_23060124_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter ifu_entry_t RST_VAL = '0
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  ifu_entry_t                   din,
  output ifu_entry_t                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   cnt,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifu_entry_t    mem_q [DEPTH];
  ifu_entry_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != '0);
    do_push  = push && ((cnt_q != DEPTH_C) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);

endmodule

// File: rtl/ifu_prefetch.sv
// Read-only AXI4 instruction prefetcher: credit-limited single-beat reads feeding a
// small buffer toward the IDU, with redirect flush and in-order discard of stale data.
module ifu_prefetch #(
  parameter int                ADDR_W          = 32,
  parameter int                ID_W            = 4,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(ysyx_23060124_pkg::RESET_PC),
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_ins,
  output logic              o_err,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  input  logic [ID_W-1:0]   M_AXI_RID,
  input  logic              M_AXI_RLAST
);

  import ysyx_23060124_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
  localparam ifu_entry_t FIFO_RST = '{pc: IFU_PC_W'(RESET_PC), ins: 32'd0, err: 1'b0};

  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              stale_ar_q, stale_ar_d;

  logic              ar_hs, r_hs;
  logic              fifo_push, fifo_pop_eff;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic [SW-1:0]     fifo_cnt_nxt, credit_used;
  ifu_entry_t        push_entry, head_entry;

  assign ar_hs        = arvalid_q & M_AXI_ARREADY;
  assign r_hs         = M_AXI_RVALID & rready_q;
  assign fifo_pop_eff = i_ready & ~fifo_empty;

  always_comb begin
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = 1'b1;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    out_cnt_d    = out_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    stale_ar_d   = stale_ar_q;
    fifo_push    = 1'b0;
    push_entry   = '{pc: IFU_PC_W'(pc_q), ins: M_AXI_RDATA,
                     err: (M_AXI_RRESP != AXI_RESP_OKAY)};

    if (ar_hs) begin
      out_cnt_d = out_cnt_q + CW'(1);
      // An AR issued before a redirect becomes one more read to discard.
      if (stale_ar_q) begin
        drop_cnt_d = drop_cnt_q + CW'(1);
        stale_ar_d = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
    end

    if (r_hs) begin
      out_cnt_d = out_cnt_d - CW'(1);
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_d - CW'(1);
      end else if (!i_redirect) begin
        fifo_push = 1'b1;
        pc_d      = pc_q + ADDR_W'(4);
      end
    end

    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      pc_d       = i_redirect_pc;
      drop_cnt_d = out_cnt_d;
      stale_ar_d = arvalid_q & ~M_AXI_ARREADY;
    end

    fifo_cnt_nxt = i_redirect ? '0
                 : SW'(fifo_cnt) + SW'(fifo_push) - SW'(fifo_pop_eff);
    credit_used  = SW'(out_cnt_d) - SW'(drop_cnt_d) + fifo_cnt_nxt;

    // Held AR keeps its address; otherwise re-arm against next-cycle credit.
    if (!(arvalid_q && !M_AXI_ARREADY)) begin
      arvalid_d = 1'b0;
      if (!i_redirect && (out_cnt_d < MAX_OUT) && (credit_used < DEPTH_S)) begin
        arvalid_d = 1'b1;
        araddr_d  = fetch_pc_d;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      arvalid_q  <= 1'b0;
      araddr_q   <= RESET_PC;
      rready_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      stale_ar_q <= 1'b0;
    end else begin
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      stale_ar_q <= stale_ar_d;
    end
  end

  ifu_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .RST_VAL (FIFO_RST)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (i_ready),
    .flush (i_redirect),
    .din   (push_entry),
    .dout  (head_entry),
    .cnt   (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign o_valid = ~fifo_empty;
  assign o_pc    = ADDR_W'(head_entry.pc);
  assign o_ins   = head_entry.ins;
  assign o_err   = head_entry.err;

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_RREADY  = rready_q;

  // Single-beat reads with one ID: RID and RLAST carry no extra information.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_RID, M_AXI_RLAST, fifo_full};

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a small AXI read slave (1-cycle latency, queued responses).
module tb_ifu_prefetch;

  logic        clock = 1'b0;
  logic        rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_ins;
  logic        o_err;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [3:0]  s_rid;
  logic        s_rlast;

  logic        arready_ctl;
  logic        r_en;
  logic [31:0] err_addr;
  logic [31:0] rq[$];
  logic [31:0] ar_log[$];
  int          ar_cnt;
  logic        ar_pend, r_pend;
  logic [31:0] ar_pend_addr;

  int n_pass = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ifu_prefetch dut (
    .clock         (clock),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_ins         (o_ins),
    .o_err         (o_err),
    .M_AXI_ARADDR  (s_araddr),
    .M_AXI_ARVALID (s_arvalid),
    .M_AXI_ARREADY (s_arready),
    .M_AXI_ARID    (s_arid),
    .M_AXI_ARLEN   (s_arlen),
    .M_AXI_ARSIZE  (s_arsize),
    .M_AXI_ARBURST (s_arburst),
    .M_AXI_RDATA   (s_rdata),
    .M_AXI_RRESP   (s_rresp),
    .M_AXI_RVALID  (s_rvalid),
    .M_AXI_RREADY  (s_rready),
    .M_AXI_RID     (s_rid),
    .M_AXI_RLAST   (s_rlast)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Slave: updates on the falling edge, so every handshake is known before the next rising edge.
  initial begin
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    s_rid = '0; s_rlast = 1'b0; ar_pend = 1'b0; r_pend = 1'b0;
    ar_pend_addr = '0; ar_cnt = 0;
    forever begin
      @(negedge clock);
      if (rst) begin
        rq.delete();
        ar_log.delete();
        ar_cnt    = 0;
        ar_pend   = 1'b0;
        r_pend    = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        s_arready = arready_ctl;
      end else begin
        if (ar_pend) begin
          rq.push_back(ar_pend_addr);
          ar_log.push_back(ar_pend_addr);
          ar_cnt++;
        end
        if (r_pend) void'(rq.pop_front());
        s_arready = arready_ctl;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = 2'b00;
        if (rq.size() > 0) begin
          s_rvalid = r_en;
          s_rdata  = ins_of(rq[0]);
          s_rresp  = (rq[0] == err_addr) ? 2'b10 : 2'b00;
        end
        s_rlast      = s_rvalid;
        ar_pend      = s_arvalid && s_arready;
        ar_pend_addr = s_araddr;
        r_pend       = s_rvalid && s_rready;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] pc, input logic err);
    int k = 0;
    while (!o_valid && k < 40) begin
      step(1);
      k++;
    end
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    if (o_valid) begin
      chk({tag, "_pc"},  o_pc, pc);
      chk({tag, "_ins"}, o_ins, ins_of(pc));
      chk({tag, "_err"}, 32'(o_err), 32'(err));
      i_ready = 1'b1;
      step(1);
      i_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
    arready_ctl = 1'b1; r_en = 1'b1; err_addr = 32'h3000_0004;
    step(2);

    // Reset state
    chk("rst_arvalid", 32'(s_arvalid), 32'd0);
    chk("rst_araddr",  s_araddr, 32'h3000_0000);
    chk("rst_rready",  32'(s_rready), 32'd0);
    chk("rst_valid",   32'(o_valid), 32'd0);
    chk("rst_pc",      o_pc, 32'h3000_0000);
    chk("rst_ins",     o_ins, 32'd0);
    chk("rst_err",     32'(o_err), 32'd0);

    rst = 1'b0;
    step(1);
    chk("first_arvalid", 32'(s_arvalid), 32'd1);
    chk("first_rready",  32'(s_rready), 32'd1);
    chk("first_araddr",  s_araddr, 32'h3000_0000);
    chk("arsize",  32'(s_arsize), 32'd2);
    chk("arburst", 32'(s_arburst), 32'd1);
    chk("arlen",   32'(s_arlen), 32'd0);
    chk("arid",    32'(s_arid), 32'd0);

    // IDU stalled: buffer credit allows exactly four reads
    step(20);
    chk("fill_ar_cnt",  32'(ar_cnt), 32'd4);
    chk("fill_arvalid", 32'(s_arvalid), 32'd0);
    pop_expect("pop0", 32'h3000_0000, 1'b0);
    step(10);
    chk("credit_ar_cnt",  32'(ar_cnt), 32'd5);
    chk("credit_arvalid", 32'(s_arvalid), 32'd0);
    pop_expect("pop1", 32'h3000_0004, 1'b1);
    pop_expect("pop2", 32'h3000_0008, 1'b0);
    pop_expect("pop3", 32'h3000_000C, 1'b0);
    pop_expect("pop4", 32'h3000_0010, 1'b0);
    chk("log1", ar_log[1], 32'h3000_0004);
    chk("log2", ar_log[2], 32'h3000_0008);

    // Two reads in flight when the redirect arrives: both beats discarded
    err_addr = 32'hFFFF_FFFF;
    r_en = 1'b0;
    do_reset();
    step(8);
    chk("out2_ar_cnt",  32'(ar_cnt), 32'd2);
    chk("out2_arvalid", 32'(s_arvalid), 32'd0);
    i_redirect = 1'b1; i_redirect_pc = 32'h8000_0000;
    step(1);
    i_redirect = 1'b0;
    chk("redir_valid",   32'(o_valid), 32'd0);
    chk("redir_arvalid", 32'(s_arvalid), 32'd0);
    r_en = 1'b1;
    pop_expect("redir_pop0", 32'h8000_0000, 1'b0);
    pop_expect("redir_pop1", 32'h8000_0004, 1'b0);
    chk("redir_log2", ar_log[2], 32'h8000_0000);

    // Redirect while an AR is held: old address stays, its data is dropped
    arready_ctl = 1'b0;
    do_reset();
    step(4);
    chk("hold_arvalid", 32'(s_arvalid), 32'd1);
    chk("hold_araddr",  s_araddr, 32'h3000_0000);
    i_redirect = 1'b1; i_redirect_pc = 32'h8000_0100;
    step(1);
    i_redirect = 1'b0;
    chk("stale_arvalid", 32'(s_arvalid), 32'd1);
    chk("stale_araddr",  s_araddr, 32'h3000_0000);
    arready_ctl = 1'b1;
    pop_expect("stale_pop", 32'h8000_0100, 1'b0);
    chk("stale_log0", ar_log[0], 32'h3000_0000);
    chk("stale_log1", ar_log[1], 32'h8000_0100);

    // Redirect, pop and R beat all on the same edge
    do_reset();
    step(15);
    chk("sc_fill_valid", 32'(o_valid), 32'd1);
    chk("sc_fill_cnt",   32'(ar_cnt), 32'd4);
    r_en = 1'b0;
    step(1);
    chk("sc_head0", o_pc, 32'h3000_0000);
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
    step(5);
    chk("sc_ar_cnt",  32'(ar_cnt), 32'd5);
    chk("sc_arvalid", 32'(s_arvalid), 32'd0);
    chk("sc_head1",   o_pc, 32'h3000_0004);
    r_en = 1'b1; i_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h9000_0000;
    step(1);
    i_redirect = 1'b0; i_ready = 1'b0;
    chk("sc_flush_valid", 32'(o_valid), 32'd0);
    pop_expect("sc_pop", 32'h9000_0000, 1'b0);
    chk("sc_log5", ar_log[5], 32'h9000_0000);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
